// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC-tagged FIFO and redirect drain; define FETCH_BYPASS_EN for zero-latency bypass
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state;
  logic [31:0] fetch_pc;
  logic [CW-1:0] outstanding, fifo_cnt, drop, inflight;
  logic [PW-1:0] pq_wr, pq_rd, ff_wr, ff_rd;
  logic [31:0] pq_mem [DEPTH];
  logic [31:0] ff_pc [DEPTH];
  logic [31:0] ff_instr [DEPTH];
  logic gnt_fire, rv_fire, byp, byp_take, push, pop;
  logic [31:0] head_instr, head_pc;
  assign imem_req_o = rst_n && state == RUN && ({1'b0, outstanding} + {1'b0, fifo_cnt} < DEPTH_C);
  assign imem_addr_o = fetch_pc;
  assign gnt_fire = imem_req_o && imem_gnt_i;
  assign rv_fire = imem_rvalid_i && outstanding != '0;
  // in-flight count after this edge; a same-cycle grant counts, a same-cycle response does not
  assign inflight = outstanding + CW'(gnt_fire) - CW'(rv_fire);
`ifdef FETCH_BYPASS_EN
  assign byp = fifo_cnt == '0 && state == RUN && rv_fire && !redirect_i;
  assign head_instr = fifo_cnt != '0 ? ff_instr[ff_rd] : imem_rdata_i;
  assign head_pc = fifo_cnt != '0 ? ff_pc[ff_rd] : pq_mem[pq_rd];
`else
  assign byp = 1'b0;
  assign head_instr = ff_instr[ff_rd];
  assign head_pc = ff_pc[ff_rd];
`endif
  assign byp_take = byp && instr_ready_i;
  assign push = state == RUN && rv_fire && !redirect_i && !byp_take;
  assign pop = fifo_cnt != '0 && instr_ready_i;
  assign instr_valid_o = fifo_cnt != '0 || byp;
  assign instr_o = instr_valid_o ? head_instr : NOP;
  assign pc_o = instr_valid_o ? head_pc : '0;
  assign pc_plus4_o = instr_valid_o ? head_pc + 32'd4 : '0;
  always_ff @(posedge clk) begin
    if (gnt_fire) pq_mem[pq_wr] <= fetch_pc;
    if (push) begin
      ff_pc[ff_wr] <= pq_mem[pq_rd];
      ff_instr[ff_wr] <= imem_rdata_i;
    end
  end
  // while draining, drop mirrors outstanding since nothing new is requested
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      fetch_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
      fifo_cnt <= '0;
      pq_wr <= '0;
      pq_rd <= '0;
      ff_wr <= '0;
      ff_rd <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
      outstanding <= inflight;
      drop <= inflight;
      state <= inflight != '0 ? DRAIN : RUN;
      fifo_cnt <= '0;
      pq_wr <= '0;
      pq_rd <= '0;
      ff_wr <= '0;
      ff_rd <= '0;
    end else begin
      fetch_pc <= gnt_fire ? fetch_pc + 32'd4 : fetch_pc;
      outstanding <= inflight;
      pq_wr <= pq_wr + PW'(gnt_fire);
      pq_rd <= pq_rd + PW'(rv_fire && state == RUN);
      ff_wr <= ff_wr + PW'(push);
      ff_rd <= ff_rd + PW'(pop);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (state == DRAIN && rv_fire) begin
        drop <= drop - CW'(1);
        state <= drop == CW'(1) ? RUN : DRAIN;
      end
    end
endmodule
